auto_gain_control_mr: RTL and testbench
=======================================

AUTO_GAIN_CONTROL_MR -- requirements
Module: auto_gain_control_mr

Interface
REQ-001 SHALL have parameter DATA_W, default 12, ADC sample width, offset-binary, mid-scale MID = 2^(DATA_W-1).
REQ-002 SHALL have parameter GAIN_STEPS, default 4, number of selectable gain ranges (>=2); GW = clog2(GAIN_STEPS).
REQ-003 SHALL have parameter WIN_LEN, default 1024, valid samples per measurement window (>=2).
REQ-004 SHALL have parameter SETTLE_CYC, default 256, adc_clk cycles ignored after any gain change (>=1).
REQ-005 SHALL have parameters HI_TH default 1800 and LO_TH default 600, peak thresholds on |x-MID|, with LO_TH < HI_TH < MID.
REQ-006 SHALL have port adc_clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port adc_valid, input, 1, adc_data qualifier.
REQ-009 SHALL have port adc_data, input, DATA_W, ADC sample.
REQ-010 SHALL have port agc_en, input, 1, 1 = automatic mode, 0 = manual mode.
REQ-011 SHALL have port manual_gain, input, GW, gain index used when agc_en=0.
REQ-012 SHALL have port gain_sel, output, GW, registered gain index; 0 = lowest gain.
REQ-013 SHALL have port gain_change, output, 1, one-cycle pulse in the cycle gain_sel takes a new value.
REQ-014 SHALL have port stable, output, 1, registered; level signal.
REQ-015 SHALL have port overrange, output, 1, one-cycle pulse on a clipped sample.
REQ-016 SHALL have port peak_out, output, DATA_W, peak |x-MID| of the last completed window.

Function
REQ-017 SHALL compute per-sample magnitude m = |adc_data - MID| in DATA_W bits; adc_data = 0 gives m = MID.
REQ-018 SHALL run FSM states MEASURE, SETTLE; reset enters SETTLE.
REQ-019 In MEASURE, each adc_valid sample SHALL update a running peak to max(peak, m) and increment a sample counter; samples with adc_valid=0 SHALL be ignored.
REQ-020 A sample is clipped if adc_data = 0 or all ones; on a clipped valid sample in MEASURE, the block SHALL pulse overrange, abort the window, step gain_sel down by 1 if >0, and enter SETTLE; the window peak SHALL be discarded and peak_out left unchanged.
REQ-021 On the WIN_LEN-th valid sample, the block SHALL latch the final peak (including that sample) into peak_out on the next edge and decide on that same edge: peak > HI_TH and gain_sel > 0 -> gain_sel-1; peak < LO_TH and gain_sel < GAIN_STEPS-1 -> gain_sel+1; otherwise hold.
REQ-022 A window that holds gain SHALL set stable=1 and restart MEASURE with peak and counter cleared; a window that changes gain SHALL enter SETTLE.
REQ-023 At a threshold saturation limit (gain_sel=0 with peak>HI_TH, or gain_sel=max with peak<LO_TH), gain SHALL hold and stable SHALL be set.
REQ-024 Any gain_sel change SHALL clear stable in the same cycle and pulse gain_change.
REQ-025 SETTLE SHALL last exactly SETTLE_CYC cycles, ignore all data, then enter MEASURE with peak and counter cleared.
REQ-026 When agc_en=0: gain_sel SHALL follow manual_gain with 1-cycle latency, clamped to GAIN_STEPS-1; stable SHALL be 0; overrange SHALL still pulse; FSM SHALL stay in SETTLE with its counter reloaded.
REQ-027 On agc_en rising 0->1, the block SHALL keep the current gain_sel and enter SETTLE with a full count.
REQ-028 Clipping SHALL take priority over window completion when both occur on the same sample.

Reset
REQ-029 With rst=1 on an edge: gain_sel=0, stable=0, gain_change=0, overrange=0, peak_out=0, counters and peak cleared, state SETTLE.
REQ-030 Reset mid-window or mid-settle SHALL discard all progress; reset SHALL override every other input.

Verification (DATA_W=12, GAIN_STEPS=4, WIN_LEN=16, SETTLE_CYC=8, HI_TH=1800, LO_TH=600)
REQ-031 Reset, agc_en=1, constant 2148 valid -> after settle, one window per step gain_sel 0->1->2->3 with 8-cycle settles; then stable=1 and peak_out=100.
REQ-032 gain_sel=3 and stable=1, then a window containing sample 3948 (m=1900) -> gain_sel=2, gain_change pulse, stable=0, peak_out=1900.
REQ-033 gain_sel=2, then sample 4095 mid-window -> overrange pulse, gain_sel=1 on the same edge, peak_out unchanged, 8-cycle settle.
REQ-034 adc_valid toggled 50% -> window completes only after 16 valid samples; amplitude 1000 (between thresholds) -> gain held, stable=1.
REQ-035 agc_en=0, manual_gain=2 -> gain_sel=2 one cycle later, stable=0; agc_en back to 1 -> 8-cycle settle before measurement starts.
REQ-036 rst asserted on the 10th sample of a window -> all outputs return to REQ-029 values next edge; a full SETTLE follows release.

Source files
------------

// File: rtl/auto_gain_control_mr.sv
// Auto gain control: tracks the peak |x-MID| over fixed windows of valid ADC samples and
// steps a registered gain index up or down, blanking the input for a settle period after each change.
module auto_gain_control_mr #(
    parameter int DATA_W     = 12,
    parameter int GAIN_STEPS = 4,
    parameter int WIN_LEN    = 1024,
    parameter int SETTLE_CYC = 256,
    parameter int HI_TH      = 1800,
    parameter int LO_TH      = 600,
    localparam int GW        = (GAIN_STEPS > 1) ? $clog2(GAIN_STEPS) : 1
) (
    input  logic              adc_clk,
    input  logic              rst,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              agc_en,
    input  logic [GW-1:0]     manual_gain,
    output logic [GW-1:0]     gain_sel,
    output logic              gain_change,
    output logic              stable,
    output logic              overrange,
    output logic [DATA_W-1:0] peak_out
);

    localparam int WCW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [DATA_W-1:0] MID         = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] HI_V        = DATA_W'(HI_TH);
    localparam logic [DATA_W-1:0] LO_V        = DATA_W'(LO_TH);
    localparam logic [GW-1:0]     MAX_GAIN    = GW'(GAIN_STEPS - 1);
    localparam logic [WCW-1:0]    WIN_LAST    = WCW'(WIN_LEN - 1);
    localparam logic [SCW-1:0]    SETTLE_LOAD = SCW'(SETTLE_CYC - 1);

    localparam logic [0:0] ST_SETTLE  = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    // Distance from mid-scale; a zero code maps to exactly MID, which still fits DATA_W bits.
    function automatic logic [DATA_W-1:0] abs_offset(input logic [DATA_W-1:0] x);
        logic signed [DATA_W:0] diff;
        logic signed [DATA_W:0] mag;
        diff = $signed({1'b0, x}) - $signed({1'b0, MID});
        mag  = (diff < 0) ? -diff : diff;
        return mag[DATA_W-1:0];
    endfunction

    function automatic logic [GW-1:0] clamp_gain(input logic [GW-1:0] g);
        return ({1'b0, g} > {1'b0, MAX_GAIN}) ? MAX_GAIN : g;
    endfunction

    function automatic logic is_clipped(input logic [DATA_W-1:0] x);
        return (x == '0) || (x == '1);
    endfunction

    logic [0:0]        state;
    logic [SCW-1:0]    settle_cnt;
    logic [WCW-1:0]    win_cnt;
    logic [DATA_W-1:0] peak_acc;

    // Stage p0: per-sample magnitude, clip flag and candidate window peak
    logic              vld_p0;
    logic              clip_p0;
    logic [DATA_W-1:0] mag_p0;
    logic [DATA_W-1:0] peak_max_p0;

    assign vld_p0      = adc_valid;
    assign clip_p0     = is_clipped(adc_data);
    assign mag_p0      = abs_offset(adc_data);
    assign peak_max_p0 = (mag_p0 > peak_acc) ? mag_p0 : peak_acc;

    logic [0:0]        state_nxt;
    logic [SCW-1:0]    settle_nxt;
    logic [WCW-1:0]    win_nxt;
    logic [DATA_W-1:0] peak_nxt;
    logic [GW-1:0]     gain_nxt;
    logic              stable_nxt;
    logic              ovr_nxt;
    logic [DATA_W-1:0] peak_out_nxt;

    always_comb begin
        state_nxt    = state;
        settle_nxt   = settle_cnt;
        win_nxt      = win_cnt;
        peak_nxt     = peak_acc;
        gain_nxt     = gain_sel;
        stable_nxt   = stable;
        ovr_nxt      = 1'b0;
        peak_out_nxt = peak_out;

        if (!agc_en) begin
            // Manual mode parks the FSM in a fully loaded settle so re-enabling always blanks first.
            gain_nxt   = clamp_gain(manual_gain);
            stable_nxt = 1'b0;
            ovr_nxt    = vld_p0 & clip_p0;
            state_nxt  = ST_SETTLE;
            settle_nxt = SETTLE_LOAD;
            win_nxt    = '0;
            peak_nxt   = '0;
        end else if (state == ST_SETTLE) begin
            if (settle_cnt == '0) begin
                state_nxt = ST_MEASURE;
                win_nxt   = '0;
                peak_nxt  = '0;
            end else begin
                settle_nxt = settle_cnt - 1'b1;
            end
        end else if (vld_p0) begin
            if (clip_p0) begin
                ovr_nxt    = 1'b1;
                state_nxt  = ST_SETTLE;
                settle_nxt = SETTLE_LOAD;
                if (gain_sel != '0) begin
                    gain_nxt = gain_sel - 1'b1;
                end
            end else if (win_cnt == WIN_LAST) begin
                peak_out_nxt = peak_max_p0;
                win_nxt      = '0;
                peak_nxt     = '0;
                if ((peak_max_p0 > HI_V) && (gain_sel != '0)) begin
                    gain_nxt   = gain_sel - 1'b1;
                    state_nxt  = ST_SETTLE;
                    settle_nxt = SETTLE_LOAD;
                end else if ((peak_max_p0 < LO_V) && (gain_sel != MAX_GAIN)) begin
                    gain_nxt   = gain_sel + 1'b1;
                    state_nxt  = ST_SETTLE;
                    settle_nxt = SETTLE_LOAD;
                end else begin
                    stable_nxt = 1'b1;
                end
            end else begin
                win_nxt  = win_cnt + 1'b1;
                peak_nxt = peak_max_p0;
            end
        end

        if (gain_nxt != gain_sel) begin
            stable_nxt = 1'b0;
        end
    end

    // Stage p1: registered control state and outputs
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state       <= ST_SETTLE;
            settle_cnt  <= SETTLE_LOAD;
            win_cnt     <= '0;
            peak_acc    <= '0;
            gain_sel    <= '0;
            gain_change <= 1'b0;
            stable      <= 1'b0;
            overrange   <= 1'b0;
            peak_out    <= '0;
        end else begin
            state       <= state_nxt;
            settle_cnt  <= settle_nxt;
            win_cnt     <= win_nxt;
            peak_acc    <= peak_nxt;
            gain_sel    <= gain_nxt;
            gain_change <= (gain_nxt != gain_sel);
            stable      <= stable_nxt;
            overrange   <= ovr_nxt;
            peak_out    <= peak_out_nxt;
        end
    end

endmodule

// File: tb/tb_auto_gain_control_mr.sv
// Bench for auto_gain_control_mr: cycle-level behavioural model built from window/settle rules,
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_auto_gain_control_mr;

    localparam int DW     = 12;
    localparam int GS     = 4;
    localparam int WIN    = 16;
    localparam int SETTLE = 8;
    localparam int HI     = 1800;
    localparam int LO     = 600;

    logic          clk;
    logic          rst;
    logic          adc_valid;
    logic [DW-1:0] adc_data;
    logic          agc_en;
    logic [1:0]    manual_gain;
    logic [1:0]    gain_sel;
    logic          gain_change;
    logic          stable;
    logic          overrange;
    logic [DW-1:0] peak_out;

    auto_gain_control_mr #(
        .DATA_W(DW), .GAIN_STEPS(GS), .WIN_LEN(WIN),
        .SETTLE_CYC(SETTLE), .HI_TH(HI), .LO_TH(LO)
    ) dut (
        .adc_clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
        .agc_en(agc_en), .manual_gain(manual_gain), .gain_sel(gain_sel),
        .gain_change(gain_change), .stable(stable), .overrange(overrange),
        .peak_out(peak_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: gain index, flags, settle cycles still to blank, magnitudes of current window
    int m_gain, m_stable, m_chg, m_ovr, m_pk, m_settle;
    int m_win[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int d, mag, old_g, p;
        bit clip;
        d     = int'(adc_data) - (1 << (DW - 1));
        mag   = (d < 0) ? -d : d;
        clip  = (adc_data == 0) || (int'(adc_data) == (1 << DW) - 1);
        old_g = m_gain;
        m_chg = 0;
        m_ovr = 0;
        if (rst) begin
            m_gain = 0; m_stable = 0; m_pk = 0; m_settle = SETTLE;
            m_win.delete();
            return;
        end
        if (!agc_en) begin
            m_gain   = (int'(manual_gain) > GS - 1) ? GS - 1 : int'(manual_gain);
            m_stable = 0;
            m_ovr    = (adc_valid && clip) ? 1 : 0;
            m_settle = SETTLE;
            m_win.delete();
        end else if (m_settle > 0) begin
            m_settle--;
            m_win.delete();
        end else if (adc_valid) begin
            if (clip) begin
                m_ovr = 1;
                if (m_gain > 0) m_gain--;
                m_settle = SETTLE;
                m_win.delete();
            end else begin
                m_win.push_back(mag);
                if (m_win.size() == WIN) begin
                    p = 0;
                    foreach (m_win[i]) if (m_win[i] > p) p = m_win[i];
                    m_pk = p;
                    m_win.delete();
                    if (p > HI && m_gain > 0) begin
                        m_gain--; m_settle = SETTLE;
                    end else if (p < LO && m_gain < GS - 1) begin
                        m_gain++; m_settle = SETTLE;
                    end else begin
                        m_stable = 1;
                    end
                end
            end
        end
        if (m_gain != old_g) begin
            m_chg = 1;
            m_stable = 0;
        end
    endtask

    task automatic compare();
        chk("gain_sel", int'(gain_sel), m_gain);
        chk("gain_change", int'(gain_change), m_chg);
        chk("stable", int'(stable), m_stable);
        chk("overrange", int'(overrange), m_ovr);
        chk("peak_out", int'(peak_out), m_pk);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit v, input int data);
        adc_valid = v;
        adc_data  = DW'(data);
        cycle();
    endtask

    // Run quiet mid-scale samples until a fresh window is about to start.
    task automatic align();
        int k;
        k = 0;
        rst = 1'b0; agc_en = 1'b1;
        while (!(m_settle == 0 && m_win.size() == 0) && k < 64) begin
            drive(1'b1, 2148);
            k++;
        end
        if (k >= 64) begin
            checks++; errors++;
            $display("FAIL align: no window boundary within %0d cycles", k);
        end
    endtask

    initial begin
        int amp, v, d;
        rst = 1'b1; adc_valid = 1'b0; adc_data = DW'(2048); agc_en = 1'b1; manual_gain = 2'd0;
        m_gain = 0; m_stable = 0; m_chg = 0; m_ovr = 0; m_pk = 0; m_settle = SETTLE;

        repeat (3) cycle();
        chk("reset_gain", int'(gain_sel), 0);
        chk("reset_peak", int'(peak_out), 0);
        rst = 1'b0;

        // Small constant signal climbs gain one window at a time
        for (int i = 0; i < 110; i++) drive(1'b1, 2148);
        chk("climb_gain", int'(gain_sel), 3);
        chk("climb_stable", int'(stable), 1);
        chk("climb_peak", int'(peak_out), 100);

        // One large sample in a window at top gain steps down
        align();
        for (int i = 0; i < WIN; i++) drive(1'b1, (i == 7) ? 3948 : 2148);
        chk("hi_gain", int'(gain_sel), 2);
        chk("hi_change", int'(gain_change), 1);
        chk("hi_stable", int'(stable), 0);
        chk("hi_peak", int'(peak_out), 1900);

        // Clip mid-window aborts and steps down on the same edge
        align();
        for (int i = 0; i < 5; i++) drive(1'b1, 2148);
        drive(1'b1, 4095);
        chk("clip_ovr", int'(overrange), 1);
        chk("clip_gain", int'(gain_sel), 1);
        chk("clip_peak", int'(peak_out), 1900);
        align();

        // Gapped valid, amplitude between thresholds
        for (int i = 0; i < 32; i++) begin
            drive(i % 2 == 0, (i % 4 == 0) ? 3048 : 1048);
            if (i == 28) begin
                chk("gap_peak_pending", int'(peak_out), 1900);
                chk("gap_stable_pending", int'(stable), 0);
            end
            if (i == 30) begin
                chk("gap_peak", int'(peak_out), 1000);
                chk("gap_stable", int'(stable), 1);
                chk("gap_gain", int'(gain_sel), 1);
            end
        end

        // Randomized traffic across amplitudes, clipping, mode flips and resets
        amp = 100;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 6))
                    0: amp = 50;   1: amp = 300;  2: amp = 700;  3: amp = 1000;
                    4: amp = 1500; 5: amp = 1900; default: amp = 2047;
                endcase
            end
            if ($urandom_range(0, 199) == 0) agc_en = ~agc_en;
            manual_gain = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 999) == 0);
            v = $urandom_range(0, 3) != 0;
            d = 2048 + int'($urandom_range(0, 2 * amp)) - amp;
            if ($urandom_range(0, 149) == 0) d = ($urandom_range(0, 1) != 0) ? 4095 : 0;
            drive(v[0], d);
        end
        rst = 1'b0; agc_en = 1'b1;

        // Manual mode, then re-enable with a full settle
        rst = 1'b1;
        drive(1'b1, 2148);
        rst = 1'b0;
        agc_en = 1'b0; manual_gain = 2'd2;
        drive(1'b1, 2148);
        chk("man_gain", int'(gain_sel), 2);
        chk("man_stable", int'(stable), 0);
        chk("man_change", int'(gain_change), 1);
        drive(1'b1, 0);
        chk("man_ovr", int'(overrange), 1);
        chk("man_hold", int'(gain_sel), 2);
        agc_en = 1'b1;
        for (int i = 0; i < SETTLE; i++) begin
            drive(1'b1, 4095);
            chk("reen_settle_ovr", int'(overrange), 0);
        end
        drive(1'b1, 4095);
        chk("reen_ovr", int'(overrange), 1);
        chk("reen_gain", int'(gain_sel), 1);

        // Reset on the 10th sample of a window
        align();
        for (int i = 0; i < 9; i++) drive(1'b1, 2148);
        rst = 1'b1;
        drive(1'b1, 2148);
        chk("rst_gain", int'(gain_sel), 0);
        chk("rst_change", int'(gain_change), 0);
        chk("rst_stable", int'(stable), 0);
        chk("rst_ovr", int'(overrange), 0);
        chk("rst_peak", int'(peak_out), 0);
        rst = 1'b0;
        for (int i = 0; i < SETTLE; i++) begin
            drive(1'b1, 4095);
            chk("rst_settle_ovr", int'(overrange), 0);
        end
        drive(1'b1, 4095);
        chk("rst_after_ovr", int'(overrange), 1);
        chk("rst_after_gain", int'(gain_sel), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
